motor_dense_seq3_ap_fixed_18_7: RTL and testbench
=================================================

Name: motor_dense_seq3_ap_fixed_18_7

Overview:
- Time-multiplexed fully-connected layer with 3 outputs, in ap_fixed<18,7> (Q18.7: 11 fraction bits) arithmetic.
- Consumes one feature per cycle and accumulates all three neurons in parallel with 3 MACs.
- Presents the three pre-activation sums to the downstream relu_config10 stage.
- ap_return_0/1/2 connect to that stage's p_read, p_read7 and p_read8 respectively.

Parameters:
- N_IN, 4, number of input features per frame (>=2).
- WEIGHTS, 0, flattened 3*N_IN*18-bit signed Q18.7 constants; element (j,k) at bits [(j*N_IN+k)*18 +: 18].
- BIASES, 0, flattened 3*18-bit signed Q18.7 biases; bias j at bits [j*18 +: 18].

Ports:
- ap_clk  in  1  clock; all logic is on the rising edge.
- ap_rst  in  1  asynchronous, active-high reset.
- in_data  in  18  signed Q18.7 feature x[k].
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts in_data this cycle.
- out_valid  out  1  ap_return_0..2 hold a complete result.
- out_ready  in  1  consumer takes the result.
- ap_return_0  out  18  neuron 0 result, signed Q18.7.
- ap_return_1  out  18  neuron 1 result.
- ap_return_2  out  18  neuron 2 result.

Behaviour:
- Reset: asynchronous and active-high, as already decided.
  - While ap_rst is high: state=ACC, cnt=0, accumulators=0, out_valid=0, ap_return_0..2=0, in_ready=0.
  - Reset mid-frame discards all partial sums. The first input accepted after reset starts a fresh frame.
- States:
  - ACC: in_ready=1. The input is accepted on an edge where in_valid&in_ready.
    - acc_j <= (cnt==0 ? 0 : acc_j) + x*W[j][cnt], for each j.
    - cnt increments. On acceptance with cnt==N_IN-1, cnt <= 0 and go to FIN.
    - Cycles without in_valid hold everything (gaps allowed).
  - FIN: in_ready=0. One cycle.
    - ap_return_j <= fix(acc_j + (B[j] <<< 11)).
    - out_valid <= 1. Go to OUT.
  - OUT: in_ready=0, outputs stable.
    - On out_valid&out_ready: out_valid <= 0, go to ACC.
    - ap_return_j keep their last value.
- Latency and throughput:
  - out_valid is high starting one cycle after the edge that accepts x[N_IN-1].
  - Back-to-back frames take N_IN+2 cycles each with in_valid and out_ready held high.
- Arithmetic:
  - Product is 36-bit signed with 22 fraction bits.
  - Accumulator is 36+clog2(N_IN)+1 bits, wide enough that it never overflows.
  - fix(): arithmetic shift right by 11, which truncates toward -inf (AP_TRN). Then keep the low 18 bits (AP_WRAP).
- Simultaneous events:
  - out_ready may be high before out_valid; this has no effect.
  - Input is never accepted in FIN or OUT.
  - ap_rst wins over any handshake on the same edge.
- Output ports are registered; there is no combinational path from inputs to ap_return_*.

Optional Feature:
- MOTOR_DENSE_SAT_EN.
- Defined: fix() saturates instead of wrapping (AP_SAT).
  - Shifted value > 131071 gives 18'h1FFFF.
  - Shifted value < -131072 gives 18'h20000.
  - Truncation toward -inf is unchanged.
- Undefined: AP_WRAP as described in Behaviour. No extra logic is generated.

Test Plan:
- Identity frame:
  - Setup: N_IN=4, all weights 2048 (1.0), biases 0, x = 2048, 4096, 6144, 8192.
  - Required: all outputs 20480 (10.0); out_valid high one cycle after the 4th accept.
- Bias and sign:
  - Setup: W[0][*]=2048, B = {-4096, 1024, 0}, W[1]=W[2]=0, x = -2048 ×4.
  - Required: ap_return_0 = -12288 (18'h3D000), ap_return_1 = 1024, ap_return_2 = 0.
- Truncation:
  - Setup: W[0][0]=1024, other weights 0, biases 0, x = -1, 0, 0, 0.
  - Required: ap_return_0 = -1 (18'h3FFFF), not 0.
- Overflow:
  - Setup: weights 2048, x = 122880 (60.0) ×4.
  - Required without the macro: the wrapped low 18 bits of 491520, i.e. 18'h38000.
  - Required with MOTOR_DENSE_SAT_EN: 18'h1FFFF.
- Backpressure:
  - Stimulus: out_ready held low for 5 cycles after out_valid rises, with in_valid held high throughout.
  - Required: outputs and out_valid held stable, in_ready=0, no input consumed; the next frame starts the cycle after out_ready rises.
- Reset mid-frame:
  - Stimulus: accept 2 inputs, pulse ap_rst asynchronously, then run the identity frame.
  - Required: result is 20480, with no contribution from the stale partial sums.

Source files
------------

// File: rtl/motor_dense_seq3_ap_fixed_18_7_if.sv
// Stream handshake and result bus between the feature source, the dense layer
// and the downstream relu_config10 stage (ap_return_0/1/2 -> p_read/p_read7/p_read8).
interface motor_dense_seq3_ap_fixed_18_7_if;
    logic signed [17:0] in_data;
    logic               in_valid;
    logic               in_ready;
    logic               out_valid;
    logic               out_ready;
    logic        [17:0] ap_return_0;
    logic        [17:0] ap_return_1;
    logic        [17:0] ap_return_2;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_valid, ap_return_0, ap_return_1, ap_return_2
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_valid, ap_return_0, ap_return_1, ap_return_2
    );
endinterface

// File: rtl/motor_dense_seq3_ap_fixed_18_7.sv
// Time-multiplexed 3-neuron dense layer, ap_fixed<18,7>, one feature per cycle.
// Define MOTOR_DENSE_SAT_EN to saturate the result instead of wrapping it.
module motor_dense_seq3_mac_lane #(
    parameter int ACC_W = 39
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               acc_en_i,
    input  logic               clr_i,
    input  logic               fin_i,
    input  logic signed [17:0] x_i,
    input  logic signed [17:0] w_i,
    input  logic signed [17:0] b_i,
    output logic        [17:0] ret_o
);
    logic signed [35:0]      prod;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic        [17:0]      ret_q, ret_d;

    assign prod  = x_i * w_i;
    assign acc_d = (clr_i ? '0 : acc_q) + $signed({{(ACC_W-36){prod[35]}}, prod});

    // The bias term has 11 zero fraction bits, so it adds straight onto the shifted sum.
`ifdef MOTOR_DENSE_SAT_EN
    localparam int SH_W = ACC_W - 10;
    logic [SH_W-1:0] shifted;
    assign shifted = {acc_q[ACC_W-1], acc_q[ACC_W-1:11]} + {{(SH_W-18){b_i[17]}}, b_i};

    always_comb begin
        ret_d = shifted[17:0];
        if (!((&shifted[SH_W-1:17]) || !(|shifted[SH_W-1:17])))
            ret_d = shifted[SH_W-1] ? 18'h20000 : 18'h1FFFF;
    end
`else
    assign ret_d = acc_q[28:11] + b_i;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= '0;
            ret_q <= '0;
        end else begin
            if (acc_en_i) acc_q <= acc_d;
            if (fin_i)    ret_q <= ret_d;
        end
    end

    assign ret_o = ret_q;
endmodule

module motor_dense_seq3_ap_fixed_18_7 #(
    parameter int                    N_IN    = 4,
    parameter logic [3*N_IN*18-1:0] WEIGHTS = '0,
    parameter logic [3*18-1:0]      BIASES  = '0
) (
    input  logic ap_clk,
    input  logic ap_rst,
    motor_dense_seq3_ap_fixed_18_7_if.slave bus
);
    localparam int CNT_W = $clog2(N_IN);
    localparam int ACC_W = 36 + $clog2(N_IN) + 1;

    typedef enum logic [1:0] {S_ACC, S_FIN, S_OUT} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ov_q, ov_d;
    logic               acc_en, fin;
    logic [2:0][17:0]   w_sel;
    logic [2:0][17:0]   ret;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ov_d    = ov_q;
        acc_en  = 1'b0;
        fin     = 1'b0;
        case (state_q)
            S_ACC: if (bus.in_valid) begin
                acc_en = 1'b1;
                if (cnt_q == CNT_W'(N_IN - 1)) begin
                    cnt_d   = '0;
                    state_d = S_FIN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FIN: begin
                fin     = 1'b1;
                ov_d    = 1'b1;
                state_d = S_OUT;
            end
            S_OUT: if (bus.out_ready) begin
                ov_d    = 1'b0;
                state_d = S_ACC;
            end
            default: state_d = S_ACC;
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q <= S_ACC;
            cnt_q   <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ov_q    <= ov_d;
        end
    end

    always_comb begin
        for (int j = 0; j < 3; j++)
            w_sel[j] = WEIGHTS[(j*N_IN + int'(cnt_q))*18 +: 18];
    end

    // cnt==0 restarts the sum, so stale partials never leak into a new frame.
    for (genvar j = 0; j < 3; j++) begin : g_lane
        motor_dense_seq3_mac_lane #(.ACC_W(ACC_W)) u_lane (
            .clk_i    (ap_clk),
            .rst_i    (ap_rst),
            .acc_en_i (acc_en),
            .clr_i    (cnt_q == '0),
            .fin_i    (fin),
            .x_i      (bus.in_data),
            .w_i      (w_sel[j]),
            .b_i      (BIASES[j*18 +: 18]),
            .ret_o    (ret[j])
        );
    end

    assign bus.in_ready    = (state_q == S_ACC) && !ap_rst;
    assign bus.out_valid   = ov_q;
    assign bus.ap_return_0 = ret[0];
    assign bus.ap_return_1 = ret[1];
    assign bus.ap_return_2 = ret[2];
endmodule

// File: tb/tb_motor_dense_seq3_ap_fixed_18_7.sv
// Bench: four layer instances with different weight sets share one stimulus
// stream; results are compared against a plain-arithmetic dot-product model.
module tb_motor_dense_seq3_ap_fixed_18_7;
    localparam logic [215:0] W_ID = {12{18'd2048}};
    localparam logic [53:0]  B_ID = '0;
    localparam logic [215:0] W_BS = {{8{18'd0}}, {4{18'd2048}}};
    localparam logic [53:0]  B_BS = {18'd0, 18'd1024, 18'h3F000};
    localparam logic [215:0] W_TR = {{11{18'd0}}, 18'd1024};
    localparam logic [53:0]  B_TR = '0;
    localparam logic [215:0] W_RN = {18'h2A5C3, 18'h01F40, 18'h3E0C1, 18'h00800,
                                     18'h35555, 18'h0ABCD, 18'h3FFFF, 18'h1FFFF,
                                     18'h20000, 18'h07777, 18'h3C3C3, 18'h00001};
    localparam logic [53:0]  B_RN = {18'h3FE00, 18'h12345, 18'h20001};

    logic ap_clk = 1'b0;
    logic ap_rst = 1'b1;
    logic signed [17:0] x_drv = '0;
    logic v_drv = 1'b0;
    logic r_drv = 1'b0;
    int errors = 0;
    int checks = 0;
    logic [17:0] act [4][3];

    motor_dense_seq3_ap_fixed_18_7_if bus0();
    motor_dense_seq3_ap_fixed_18_7_if bus1();
    motor_dense_seq3_ap_fixed_18_7_if bus2();
    motor_dense_seq3_ap_fixed_18_7_if bus3();

    assign bus0.in_data = x_drv; assign bus0.in_valid = v_drv; assign bus0.out_ready = r_drv;
    assign bus1.in_data = x_drv; assign bus1.in_valid = v_drv; assign bus1.out_ready = r_drv;
    assign bus2.in_data = x_drv; assign bus2.in_valid = v_drv; assign bus2.out_ready = r_drv;
    assign bus3.in_data = x_drv; assign bus3.in_valid = v_drv; assign bus3.out_ready = r_drv;

    motor_dense_seq3_ap_fixed_18_7 #(.N_IN(4), .WEIGHTS(W_ID), .BIASES(B_ID))
        u_id (.ap_clk(ap_clk), .ap_rst(ap_rst), .bus(bus0));
    motor_dense_seq3_ap_fixed_18_7 #(.N_IN(4), .WEIGHTS(W_BS), .BIASES(B_BS))
        u_bs (.ap_clk(ap_clk), .ap_rst(ap_rst), .bus(bus1));
    motor_dense_seq3_ap_fixed_18_7 #(.N_IN(4), .WEIGHTS(W_TR), .BIASES(B_TR))
        u_tr (.ap_clk(ap_clk), .ap_rst(ap_rst), .bus(bus2));
    motor_dense_seq3_ap_fixed_18_7 #(.N_IN(4), .WEIGHTS(W_RN), .BIASES(B_RN))
        u_rn (.ap_clk(ap_clk), .ap_rst(ap_rst), .bus(bus3));

    always_comb begin
        act[0][0] = bus0.ap_return_0; act[0][1] = bus0.ap_return_1; act[0][2] = bus0.ap_return_2;
        act[1][0] = bus1.ap_return_0; act[1][1] = bus1.ap_return_1; act[1][2] = bus1.ap_return_2;
        act[2][0] = bus2.ap_return_0; act[2][1] = bus2.ap_return_1; act[2][2] = bus2.ap_return_2;
        act[3][0] = bus3.ap_return_0; act[3][1] = bus3.ap_return_1; act[3][2] = bus3.ap_return_2;
    end

    always #5 ap_clk = ~ap_clk;

    // Reference: y_j = floor((sum_k x_k*W[j][k] + B[j]*2^11) / 2^11), then wrap or clamp to 18 bits.
    function automatic logic [17:0] ref_out(input int inst, input int xs[4], input int j);
        logic [215:0] w;
        logic [53:0]  b;
        longint       s;
        case (inst)
            0:       begin w = W_ID; b = B_ID; end
            1:       begin w = W_BS; b = B_BS; end
            2:       begin w = W_TR; b = B_TR; end
            default: begin w = W_RN; b = B_RN; end
        endcase
        s = longint'($signed(b[j*18 +: 18])) * 2048;
        for (int k = 0; k < 4; k++)
            s += longint'(xs[k]) * longint'($signed(w[(j*4+k)*18 +: 18]));
        s = s >>> 11;
`ifdef MOTOR_DENSE_SAT_EN
        if (s > 131071)  return 18'h1FFFF;
        if (s < -131072) return 18'h20000;
`endif
        return 18'(s);
    endfunction

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    // Stimulus only: feed one frame, optional random idle gaps, ends 1 ns after the last accepting edge.
    task automatic send_frame(input int xs[4], input int max_gap);
        for (int k = 0; k < 4; k++) begin
            int t;
            v_drv = 1'b0;
            repeat ((max_gap > 0) ? $urandom_range(0, max_gap) : 0) step();
            v_drv = 1'b1;
            x_drv = 18'(xs[k]);
            t = 0;
            while (!bus0.in_ready && t < 20) begin step(); t++; end
            if (t == 20) begin
                errors++;
                $display("FAIL send_timeout: in_ready=%0b required 1", bus0.in_ready);
            end
            step();
        end
        v_drv = 1'b0;
    endtask

    task automatic release_out();
        r_drv = 1'b1;
        step();
        r_drv = 1'b0;
    endtask

    function automatic int rand_x();
        logic [17:0] r;
        r = 18'($urandom);
        return int'($signed(r));
    endfunction

    task automatic test_reset();
        step(); step();
        checks++;
        if (bus0.out_valid !== 1'b0 || bus0.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: out_valid=%0b in_ready=%0b required 0 0", bus0.out_valid, bus0.in_ready);
        end
        for (int i = 0; i < 4; i++) for (int j = 0; j < 3; j++) begin
            checks++;
            if (act[i][j] !== 18'd0) begin
                errors++;
                $display("FAIL reset_ret[%0d][%0d]: got %h required 0", i, j, act[i][j]);
            end
        end
        ap_rst = 1'b0;
        #1;
        checks++;
        if (bus0.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %0b required 1", bus0.in_ready);
        end
    endtask

    task automatic test_identity();
        int xs[4];
        xs = '{2048, 4096, 6144, 8192};
        send_frame(xs, 0);
        checks++;
        if (bus0.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ident_fin_valid: got %0b required 0", bus0.out_valid);
        end
        step();
        checks++;
        if (bus0.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL ident_latency: out_valid=%0b required 1", bus0.out_valid);
        end
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (act[0][j] !== 18'd20480) begin
                errors++;
                $display("FAIL ident_ret%0d: got %0d required 20480", j, act[0][j]);
            end
        end
        for (int i = 1; i < 4; i++) for (int j = 0; j < 3; j++) begin
            checks++;
            if (act[i][j] !== ref_out(i, xs, j)) begin
                errors++;
                $display("FAIL ident_model[%0d][%0d]: got %h required %h", i, j, act[i][j], ref_out(i, xs, j));
            end
        end
        release_out();
        checks++;
        if (bus0.out_valid !== 1'b0 || bus0.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ident_release: out_valid=%0b in_ready=%0b required 0 1", bus0.out_valid, bus0.in_ready);
        end
    endtask

    task automatic test_bias_sign();
        int xs[4];
        logic [17:0] req [3];
        xs  = '{-2048, -2048, -2048, -2048};
        req = '{18'h3D000, 18'd1024, 18'd0};
        send_frame(xs, 1);
        step();
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (act[1][j] !== req[j]) begin
                errors++;
                $display("FAIL bias_ret%0d: got %h required %h", j, act[1][j], req[j]);
            end
        end
        release_out();
    endtask

    task automatic test_truncation();
        int xs[4];
        xs = '{-1, 0, 0, 0};
        send_frame(xs, 0);
        step();
        checks++;
        if (act[2][0] !== 18'h3FFFF) begin
            errors++;
            $display("FAIL trunc_ret0: got %h required 3ffff", act[2][0]);
        end
        release_out();
    endtask

    task automatic test_overflow();
        int xs[4];
        logic [17:0] req;
`ifdef MOTOR_DENSE_SAT_EN
        req = 18'h1FFFF;
`else
        req = 18'h38000;
`endif
        xs = '{122880, 122880, 122880, 122880};
        send_frame(xs, 0);
        step();
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (act[0][j] !== req) begin
                errors++;
                $display("FAIL ovf_ret%0d: got %h required %h", j, act[0][j], req);
            end
        end
        checks++;
        if (act[3][0] !== ref_out(3, xs, 0)) begin
            errors++;
            $display("FAIL ovf_model: got %h required %h", act[3][0], ref_out(3, xs, 0));
        end
        release_out();
    endtask

    task automatic test_backpressure();
        int xs[4];
        int nx[4];
        for (int k = 0; k < 4; k++) begin xs[k] = rand_x(); nx[k] = rand_x(); end
        send_frame(xs, 0);
        step();
        v_drv = 1'b1;
        x_drv = 18'(nx[0]);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (bus0.out_valid !== 1'b1 || bus0.in_ready !== 1'b0 || act[3][c % 3] !== ref_out(3, xs, c % 3)) begin
                errors++;
                $display("FAIL bp_hold c%0d: valid=%0b ready=%0b ret=%h required 1 0 %h",
                         c, bus0.out_valid, bus0.in_ready, act[3][c % 3], ref_out(3, xs, c % 3));
            end
            step();
        end
        release_out();
        checks++;
        if (bus0.out_valid !== 1'b0 || bus0.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: valid=%0b ready=%0b required 0 1", bus0.out_valid, bus0.in_ready);
        end
        for (int k = 1; k < 4; k++) begin
            step();
            x_drv = 18'(nx[k]);
        end
        step();
        v_drv = 1'b0;
        step();
        for (int i = 0; i < 4; i++) for (int j = 0; j < 3; j++) begin
            checks++;
            if (act[i][j] !== ref_out(i, nx, j)) begin
                errors++;
                $display("FAIL bp_next[%0d][%0d]: got %h required %h", i, j, act[i][j], ref_out(i, nx, j));
            end
        end
        release_out();
    endtask

    task automatic test_reset_mid();
        int xs[4];
        v_drv = 1'b1;
        x_drv = 18'(rand_x()); step();
        x_drv = 18'(rand_x()); step();
        v_drv = 1'b0;
        #3 ap_rst = 1'b1;
        #1;
        checks++;
        if (bus0.in_ready !== 1'b0 || bus0.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_hs: ready=%0b valid=%0b required 0 0", bus0.in_ready, bus0.out_valid);
        end
        #1 ap_rst = 1'b0;
        step();
        xs = '{2048, 4096, 6144, 8192};
        send_frame(xs, 0);
        step();
        for (int i = 0; i < 4; i++) for (int j = 0; j < 3; j++) begin
            checks++;
            if (act[i][j] !== ref_out(i, xs, j) || (i == 0 && act[i][j] !== 18'd20480)) begin
                errors++;
                $display("FAIL rstmid[%0d][%0d]: got %h required %h", i, j, act[i][j], ref_out(i, xs, j));
            end
        end
        release_out();
    endtask

    task automatic test_back_to_back();
        int all[12];
        int fx[4];
        int ptr = 0, oidx = 0, last = 0, c = 0;
        for (int k = 0; k < 12; k++) all[k] = rand_x();
        r_drv = 1'b1;
        while (oidx < 3 && c < 60) begin
            if (bus0.out_valid) begin
                for (int k = 0; k < 4; k++) fx[k] = all[oidx*4 + k];
                for (int j = 0; j < 3; j++) begin
                    checks++;
                    if (act[3][j] !== ref_out(3, fx, j)) begin
                        errors++;
                        $display("FAIL b2b_f%0d_ret%0d: got %h required %h", oidx, j, act[3][j], ref_out(3, fx, j));
                    end
                end
                if (oidx > 0) begin
                    checks++;
                    if (c - last != 6) begin
                        errors++;
                        $display("FAIL b2b_period: got %0d cycles required 6", c - last);
                    end
                end
                last = c;
                oidx++;
            end
            if (bus0.in_ready) begin
                if (ptr < 12) begin v_drv = 1'b1; x_drv = 18'(all[ptr]); ptr++; end
                else v_drv = 1'b0;
            end
            step();
            c++;
        end
        checks++;
        if (oidx != 3) begin
            errors++;
            $display("FAIL b2b_timeout: frames=%0d required 3", oidx);
        end
        r_drv = 1'b0;
        v_drv = 1'b0;
        step(); step();
    endtask

    task automatic test_random();
        int xs[4];
        for (int f = 0; f < 15; f++) begin
            int t = 0;
            for (int k = 0; k < 4; k++) xs[k] = rand_x();
            r_drv = $urandom_range(0, 1) == 1;
            send_frame(xs, 2);
            r_drv = 1'b0;
            while (!bus0.out_valid && t < 10) begin step(); t++; end
            repeat ($urandom_range(0, 3)) step();
            for (int i = 0; i < 4; i++) for (int j = 0; j < 3; j++) begin
                checks++;
                if (bus0.out_valid !== 1'b1 || act[i][j] !== ref_out(i, xs, j)) begin
                    errors++;
                    $display("FAIL rand_f%0d[%0d][%0d]: valid=%0b got %h required %h",
                             f, i, j, bus0.out_valid, act[i][j], ref_out(i, xs, j));
                end
            end
            release_out();
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_bias_sign();
        test_truncation();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
